// File: rtl/seq_pkg.sv
// Shared constants for the bit-serial link: default word width and the
// deserializer state encoding.
package seq_pkg;

    localparam int SEQ_WIDTH_DEF = 8;

    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/seq_unshift.sv
// Serial-in/parallel-out deserializer with SYNC word alignment and a one-entry
// valid/ready output buffer; a word finishing into a full buffer sets OVF.
module seq_unshift
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             SYNC,
    input  logic             IN,
    output logic [WIDTH-1:0] OUT,
    output logic             VALID,
    input  logic             READY,
    output logic             OVF
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-2:0] sr;

    logic             take;
    logic             restart;
    logic             done;
    logic [WIDTH-1:0] word;
    logic [WIDTH-2:0] sr_next;

    // The shift register never needs clearing on SYNC: exactly WIDTH bits are
    // shifted between alignment and completion, flushing any older bits.
    always_comb begin
        restart = E && SYNC;
        take    = E && (SYNC || (state == ST_SHIFT));
        done    = E && !SYNC && (state == ST_SHIFT) && (cnt == CNT_LAST);
        if (MSB_FIRST) begin
            word    = {sr, IN};
            sr_next = word[WIDTH-2:0];
        end else begin
            word    = {IN, sr};
            sr_next = word[WIDTH-1:1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_HUNT;
            cnt   <= '0;
            sr    <= '0;
            OUT   <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            if (take) begin
                sr <= sr_next;
            end

            if (restart) begin
                state <= ST_SHIFT;
                cnt   <= CNT_ONE;
            end else if (done) begin
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + CNT_ONE;
            end

            // A completing word may replace a word being consumed this same edge.
            if (done) begin
                if (!VALID || READY) begin
                    OUT   <= word;
                    VALID <= 1'b1;
                end else begin
                    OVF <= 1'b1;
                end
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_unshift.sv
// Bench for seq_unshift: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a bit-queue model.
module tb_seq_unshift;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         E = 1'b0;
    logic         SYNC = 1'b0;
    logic         IN = 1'b0;
    logic         READY = 1'b0;
    logic [W-1:0] out_m, out_l;
    logic         valid_m, valid_l, ovf_m, ovf_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits received since alignment, plus one buffer per ordering.
    bit           q[$];
    bit           hunt = 1'b1;
    logic [W-1:0] e_out[2];
    bit           e_vld[2];
    bit           e_ovf[2];

    always #5 CLK = ~CLK;

    seq_unshift #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .RST(RST), .E(E), .SYNC(SYNC), .IN(IN),
        .OUT(out_m), .VALID(valid_m), .READY(READY), .OVF(ovf_m)
    );

    seq_unshift #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .RST(RST), .E(E), .SYNC(SYNC), .IN(IN),
        .OUT(out_l), .VALID(valid_l), .READY(READY), .OVF(ovf_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit e, input bit sync, input bit din, input bit rdy);
        bit           done;
        logic [W-1:0] w[2];
        if (rst) begin
            q.delete();
            hunt = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e_out[k] = '0;
                e_vld[k] = 1'b0;
                e_ovf[k] = 1'b0;
            end
            return;
        end
        done = 1'b0;
        w[0] = '0;
        w[1] = '0;
        if (e) begin
            if (sync) begin
                q.delete();
                q.push_back(din);
                hunt = 1'b0;
            end else if (!hunt) begin
                q.push_back(din);
                if (q.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        w[0][W-1-i] = q[i];
                        w[1][i]     = q[i];
                    end
                    q.delete();
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (done) begin
                if (!e_vld[k] || rdy) begin
                    e_out[k] = w[k];
                    e_vld[k] = 1'b1;
                end else begin
                    e_ovf[k] = 1'b1;
                end
            end else if (e_vld[k] && rdy) begin
                e_vld[k] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit e, input bit sync, input bit din, input bit rdy);
        RST   = rst;
        E     = e;
        SYNC  = sync;
        IN    = din;
        READY = rdy;
        model_step(rst, e, sync, din, rdy);
        @(posedge CLK);
        #1;
        chk("out_m", 32'(out_m), 32'(e_out[0]));
        chk("vld_m", 32'(valid_m), 32'(e_vld[0]));
        chk("ovf_m", 32'(ovf_m), 32'(e_ovf[0]));
        chk("out_l", 32'(out_l), 32'(e_out[1]));
        chk("vld_l", 32'(valid_l), 32'(e_vld[1]));
        chk("ovf_l", 32'(ovf_l), 32'(e_ovf[1]));
    endtask

    task automatic send_word(input logic [W-1:0] wd, input bit sync, input bit rdy, input bit rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, sync && (i == W - 1), wd[i], (i == 0) ? rdy_last : rdy);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_out", 32'(out_m), 32'h0);
        chk("rst_vld", 32'(valid_m), 32'h0);
        chk("rst_ovf", 32'(ovf_m), 32'h0);
    endtask

    initial begin
        do_reset();

        // Unaligned bits are ignored while hunting.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        chk("t1_vld", 32'(valid_m), 32'h0);
        chk("t1_out", 32'(out_m), 32'h0);

        // Single aligned word, consumed immediately.
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        chk("t2_out_m", 32'(out_m), 32'hA5);
        chk("t2_out_l", 32'(out_l), 32'hA5);
        chk("t2_vld", 32'(valid_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_vld_drop", 32'(valid_m), 32'h0);

        // Back-to-back words into a stalled buffer.
        do_reset();
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        chk("t3_out", 32'(out_m), 32'h3C);
        chk("t3_ovf", 32'(ovf_m), 32'h1);
        chk("t3_vld", 32'(valid_m), 32'h1);

        // Consumer accepts exactly as the second word completes.
        do_reset();
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b1);
        chk("t4_out", 32'(out_m), 32'hC3);
        chk("t4_vld", 32'(valid_m), 32'h1);
        chk("t4_ovf", 32'(ovf_m), 32'h0);

        // Partial word abandoned by a new SYNC.
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(8'hFF, 1'b1, 1'b1, 1'b1);
        chk("t5_out", 32'(out_m), 32'hFF);
        chk("t5_vld", 32'(valid_m), 32'h1);

        // LSB-first ordering and mid-word reset.
        do_reset();
        send_word(8'h01, 1'b1, 1'b1, 1'b1);
        chk("t6_out_l", 32'(out_l), 32'h80);
        chk("t6_out_m", 32'(out_m), 32'h01);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        chk("t6_rst_vld", 32'(valid_l), 32'h0);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t6_after_rst", 32'(out_m), 32'hA5);

        // Randomized traffic, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
